// File: rtl/ps2_keys_pkg.sv
// Scan-code constants, key indices and the enums shared by the PS/2 key sequencer.
package ps2_keys_pkg;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_HIT   = 8'h33;
  localparam logic [7:0] SC_STAND = 8'h1B;
  localparam logic [7:0] SC_DEAL  = 8'h23;

  localparam logic [1:0] KEY_HIT   = 2'd0;
  localparam logic [1:0] KEY_STAND = 2'd1;
  localparam logic [1:0] KEY_DEAL  = 2'd2;

  typedef enum logic [1:0] {
    CMD_HIT   = 2'd0,
    CMD_STAND = 2'd1,
    CMD_DEAL  = 2'd2
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BRK,
    ST_EXT,
    ST_EXT_BRK
  } pstate_e;
endpackage

// File: rtl/ps2_prefix_timer.sv
// Counts idle cycles after a prefix byte; flags when the prefix has gone stale.
module ps2_prefix_timer #(
  parameter int TIMEOUT_CYCLES = 2_500_000
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [W-1:0] cnt_q;

  assign expired_o = (cnt_q == W'(TIMEOUT_CYCLES - 1));

  // Saturates at the limit so a stalled FSM never wraps back into range.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)                  cnt_q <= '0;
    else if (clr_i)               cnt_q <= '0;
    else if (en_i && !expired_o)  cnt_q <= cnt_q + W'(1);
  end
endmodule

// File: rtl/ps2_key_sequencer.sv
// PS/2 byte-stream parser turning first key presses into gated one-shot game commands.
module ps2_key_sequencer
  import ps2_keys_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 2_500_000,
  parameter logic [7:0] CODE_HIT       = SC_HIT,
  parameter logic [7:0] CODE_STAND     = SC_STAND,
  parameter logic [7:0] CODE_DEAL      = SC_DEAL
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_data_en,
  input  logic [2:0] accept_mask,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [1:0] cmd_code,
  output logic [2:0] held,
  output logic       drop_pulse
);
  pstate_e    state_q;
  logic [2:0] held_q;
  logic       cmd_valid_q;
  cmd_e       cmd_code_q;
  logic       drop_q;

  logic       is_key;
  logic [1:0] kidx;
  logic       buf_free;
  logic       expired;

  always_comb begin
    is_key = 1'b1;
    kidx   = KEY_HIT;
    if      (rx_data == CODE_HIT)   kidx = KEY_HIT;
    else if (rx_data == CODE_STAND) kidx = KEY_STAND;
    else if (rx_data == CODE_DEAL)  kidx = KEY_DEAL;
    else                            is_key = 1'b0;
  end

  // A full buffer being drained this very cycle can take the new command.
  assign buf_free = !cmd_valid_q || cmd_ready;

  ps2_prefix_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .gclk      (CLOCK_50),
    .grst_n    (reset),
    .clr_i     (rx_data_en || (state_q == ST_IDLE)),
    .en_i      (state_q != ST_IDLE),
    .expired_o (expired)
  );

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      held_q      <= '0;
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= CMD_HIT;
      drop_q      <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      if (cmd_valid_q && cmd_ready) cmd_valid_q <= 1'b0;
      if (rx_data_en) begin
        case (state_q)
          ST_IDLE: begin
            if (rx_data == SC_BRK)      state_q <= ST_BRK;
            else if (rx_data == SC_EXT) state_q <= ST_EXT;
            else if (is_key && !held_q[kidx]) begin
              held_q[kidx] <= 1'b1;
              if (accept_mask[kidx]) begin
                if (buf_free) begin
                  cmd_valid_q <= 1'b1;
                  cmd_code_q  <= cmd_e'(kidx);
                end else begin
                  drop_q <= 1'b1;
                end
              end
            end
          end
          ST_BRK: begin
            if (is_key) held_q[kidx] <= 1'b0;
            state_q <= ST_IDLE;
          end
          ST_EXT:  state_q <= (rx_data == SC_BRK) ? ST_EXT_BRK : ST_IDLE;
          default: state_q <= ST_IDLE;
        endcase
      end else if (expired && state_q != ST_IDLE) begin
        state_q <= ST_IDLE;
      end
    end
  end

  assign cmd_valid  = cmd_valid_q;
  assign cmd_code   = cmd_code_q;
  assign held       = held_q;
  assign drop_pulse = drop_q;
endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Scoreboard bench: a prefix/held/queue reference model predicts commands; a monitor checks them.
module tb_ps2_key_sequencer;
  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_en = 1'b0;
  logic [2:0] mask = 3'b000;
  logic       rdy = 1'b0;
  logic       cmd_valid;
  logic [1:0] cmd_code;
  logic [2:0] held;
  logic       drop_pulse;

  int errors = 0;
  int checks = 0;
  int n_cmds = 0;
  int rdy_mode = 0;   // 0 never ready, 1 always ready, 2 random

  // reference model state
  logic [2:0] m_held = 3'b000;
  logic       m_drop = 1'b0;
  logic [1:0] q[$];
  logic [7:0] pfx[$];
  int cyc = 0;
  int last_cyc = 0;

  ps2_key_sequencer #(.TIMEOUT_CYCLES(T)) dut (
    .CLOCK_50    (clk),
    .reset       (rst_n),
    .rx_data     (rx_data),
    .rx_data_en  (rx_en),
    .accept_mask (mask),
    .cmd_ready   (rdy),
    .cmd_valid   (cmd_valid),
    .cmd_code    (cmd_code),
    .held        (held),
    .drop_pulse  (drop_pulse)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int key_of(input logic [7:0] b);
    case (b)
      8'h33:   return 0;
      8'h1B:   return 1;
      8'h23:   return 2;
      default: return -1;
    endcase
  endfunction

  // Reference model: interprets each byte from the pending prefix list.
  always @(posedge clk) if (rst_n) begin
    cyc++;
    m_drop = 1'b0;
    if (rx_en) begin
      int k;
      k = key_of(rx_data);
      if (pfx.size() != 0 && (cyc - last_cyc) > T) pfx.delete();
      last_cyc = cyc;
      if (pfx.size() == 0) begin
        if (rx_data == 8'hF0 || rx_data == 8'hE0) pfx.push_back(rx_data);
        else if (k >= 0 && !m_held[k]) begin
          m_held[k] = 1'b1;
          if (mask[k]) begin
            if (q.size() == 0) q.push_back(k[1:0]);
            else m_drop = 1'b1;
          end
        end
      end else if (pfx.size() == 1 && pfx[0] == 8'hF0) begin
        if (k >= 0) m_held[k] = 1'b0;
        pfx.delete();
      end else if (pfx.size() == 1) begin
        if (rx_data == 8'hF0) pfx.push_back(rx_data);
        else pfx.delete();
      end else begin
        pfx.delete();
      end
    end
  end

  // Monitor: compares every cycle, pops on each handshake.
  always @(negedge clk) if (rst_n) begin
    logic [1:0] exp_code;
    chk("held", held, m_held);
    chk("drop_pulse", drop_pulse, m_drop);
    chk("cmd_valid", cmd_valid, (q.size() != 0) ? 1 : 0);
    if (q.size() != 0 && rdy) begin
      exp_code = q.pop_front();
      chk("cmd_code", cmd_code, exp_code);
      n_cmds++;
    end
  end

  function automatic logic pick_rdy();
    case (rdy_mode)
      0:       return 1'b0;
      1:       return 1'b1;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      rdy = pick_rdy();
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    @(posedge clk); #1;
    rx_data = b;
    rx_en   = 1'b1;
    rdy     = pick_rdy();
    @(posedge clk); #1;
    rx_en = 1'b0;
    rdy   = pick_rdy();
    idle(gap);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    rx_en = 1'b0;
    m_held = 3'b000;
    m_drop = 1'b0;
    q.delete();
    pfx.delete();
    #2;
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cmd_code", cmd_code, 0);
    chk("rst_held", held, 0);
    chk("rst_drop", drop_pulse, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] pool [6];
    pool[0] = 8'h33; pool[1] = 8'h1B; pool[2] = 8'h23;
    pool[3] = 8'hF0; pool[4] = 8'hE0; pool[5] = 8'h5A;

    do_reset();

    // HIT press, handshake, then release
    mask = 3'b111; rdy_mode = 0;
    send(8'h33, 3);
    rdy_mode = 1; idle(2);
    send(8'hF0, 1); send(8'h33, 2);

    // typematic STAND repeats collapse to one command per press
    send(8'h1B, 1); send(8'h1B, 1); send(8'h1B, 1);
    send(8'hF0, 1); send(8'h1B, 1);
    send(8'h1B, 2);
    send(8'hF0, 1); send(8'h1B, 2);

    // masked DEAL press is never issued later
    mask = 3'b011;
    send(8'h23, 1);
    mask = 3'b111; idle(4);
    send(8'hF0, 1); send(8'h23, 2);

    // full buffer drops DEAL, then the same with ready on the DEAL cycle
    rdy_mode = 0;
    send(8'h33, 1); send(8'h23, 3);
    rdy_mode = 1; idle(2);
    send(8'hF0, 1); send(8'h33, 1); send(8'hF0, 1); send(8'h23, 1);
    rdy_mode = 0;
    send(8'h33, 1);
    rdy_mode = 1;
    send(8'h23, 3);
    send(8'hF0, 1); send(8'h33, 1); send(8'hF0, 1); send(8'h23, 2);

    // extended break of 33 must not release HIT
    send(8'h33, 1);
    send(8'hE0, 1); send(8'hF0, 1); send(8'h33, 2);
    send(8'h1B, 2);
    send(8'hF0, 1); send(8'h1B, 1); send(8'hF0, 1); send(8'h33, 2);

    // stale prefix times out, next 33 is a make
    send(8'hF0, T + 10);
    send(8'h33, 3);
    send(8'hF0, 1); send(8'h33, 2);

    // reset after a break prefix
    send(8'hF0, 1);
    do_reset();
    send(8'h33, 3);

    // randomized traffic
    rdy_mode = 2;
    for (int i = 0; i < 400; i++) begin
      mask = 3'($urandom_range(0, 7));
      send(pool[$urandom_range(0, 5)],
           ($urandom_range(0, 19) == 0) ? T + 10 : int'($urandom_range(0, 5)));
    end

    rdy_mode = 1;
    idle(6);
    chk("drained", cmd_valid, 0);
    chk("cmds_seen", (n_cmds > 10) ? 1 : 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
